boot_loader: RTL and testbench
==============================

# boot_loader

Upstream of the single-cycle CPU core. Receives a program image as a byte stream, writes it word by word into instruction memory, and verifies a checksum. Holds the core in reset until the image has loaded and verified. On success the core is released and fetches from word address 0. On failure the core stays held in reset.

## Interface
- ADDR_WIDTH, 12: instruction-memory word-address width; matches pc[13:2]; capacity is 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5: frame start marker.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; one clock domain, no other reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte; a byte is consumed on any edge where rx_valid && rx_ready.
- im_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
- im_addr  output  ADDR_WIDTH  word address for the write.
- im_wdata  output  32  word to write.
- cpu_reset  output  1  active-high hold for the CPU; registered.
- done  output  1  image loaded and checksum matched; sticky.
- error  output  1  frame rejected; sticky.

## Operation
- FSM states: IDLE, HDR, DATA, CSUM, DONE, ERROR.
- IDLE:
  - accepted byte == SYNC_BYTE goes to HDR.
  - any other byte is discarded; stay in IDLE.
- HDR:
  - accept 4 bytes, big-endian, into word count N (32 bits).
  - After the 4th byte: N > 2^ADDR_WIDTH goes to ERROR.
  - N == 0 goes to CSUM.
  - otherwise go to DATA with word address 0 and running sum 0.
- DATA:
  - assemble words big-endian from 4 bytes; 2-bit byte counter.
  - On the 4th byte: register the word onto im_wdata and im_addr, pulse im_we, add the word to the running sum (mod 2^32), increment the word address.
  - After word N-1, go to CSUM.
- CSUM:
  - accept 4 bytes, big-endian.
  - After the 4th byte: value == running sum goes to DONE; otherwise goes to ERROR.
  - N is not included in the sum.
- DONE: cpu_reset=0, done=1. Ignore rx until reset.
- ERROR: cpu_reset=1, error=1. Ignore rx until reset; no resync.
- rx_ready:
  - combinational from state: 1 in IDLE/HDR/DATA/CSUM, 0 in DONE/ERROR.
  - No backpressure during loading; back-to-back bytes are always accepted.
- Bytes arriving with rx_valid=0 are never consumed; gaps of any length between bytes are legal.
- Word address never wraps: the N limit ensures a maximum address of 2^ADDR_WIDTH-1.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state=IDLE, byte counter=0, word address=0, sum=0.
  - im_we=0, im_addr=0, im_wdata=0.
  - cpu_reset=1, done=0, error=0, rx_ready=1.
- Write latency: 4th byte of word k accepted at edge t gives im_we=1, im_addr=k, im_wdata=word during cycle t..t+1.
  - im_we drops at edge t+1 unless another word completes, which is impossible with fewer than 4 bytes.
- The byte accepted at edge t+1 overlaps the write with no conflict.
- Terminal states: last checksum byte accepted at edge t gives the state change at edge t; from cycle t, done/cpu_reset (DONE) or error (ERROR) hold and rx_ready=0.
- Oversized N: the ERROR transition happens at the edge accepting the 4th header byte; no im_we is ever issued.
- Reset mid-frame:
  - all counters, sum and outputs return to reset values immediately.
  - memory contents already written are left as they are.
  - a new frame must begin with SYNC_BYTE.

## Test plan
- Reset then A5, 00 00 00 02, 00 00 00 04, 20 08 00 05, checksum 20 08 00 09 ->
  - im_we pulses at addr 0 (0x00000004) and addr 1 (0x20080005);
  - then done=1, cpu_reset=0, rx_ready=0.
- Same frame with checksum 20 08 00 0A -> both writes occur; error=1, cpu_reset stays 1, done=0.
- Leading bytes 00 FF 3C before A5, with rx_valid gaps of 0-5 idle cycles between every byte -> garbage discarded; result identical to the first scenario.
- A5, 00 00 10 01 (N=4097, ADDR_WIDTH=12) -> error=1 at the 4th header byte; no im_we; rx_ready=0.
- A5, 00 00 00 00, 00 00 00 00 -> no writes; done=1.
- Assert reset after 2 of 4 bytes of word 1 in the first scenario -> all outputs return to reset values; a full retransmit then ends with done=1.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: receives a program image as a byte stream, writes it word by
// word into instruction memory and verifies a trailing checksum. The CPU core
// is held in reset until the image has loaded and the checksum has matched.
//
// Frame: SYNC_BYTE, N (4 bytes, big-endian word count), N data words
// (4 bytes each, big-endian), checksum (4 bytes, big-endian, sum of the data
// words mod 2^32; N is not part of the sum).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   rx_data    incoming byte
//   rx_valid   rx_data valid this cycle
//   rx_ready   loader accepts a byte (byte consumed when rx_valid && rx_ready)
//   im_we      instruction-memory write strobe, one-cycle pulse per word
//   im_addr    word address for the write
//   im_wdata   word to write
//   cpu_reset  active-high hold for the CPU core (registered)
//   done       image loaded and checksum matched (sticky until reset)
//   error      frame rejected (sticky until reset)
//
// Handshake: a byte transfers on every rising edge where rx_valid && rx_ready.
// rx_ready depends only on the FSM state, so while loading every byte is
// accepted back-to-back; gaps with rx_valid=0 are ignored.
module boot_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  // Largest legal word count: the whole instruction memory.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t                state;
  state_t                state_next;
  logic [1:0]            byte_cnt;
  logic [23:0]           shreg;
  logic [31:0]           word_count;
  logic [31:0]           sum;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  accept;
  logic                  word_full;
  logic [31:0]           cur_word;
  logic                  last_word;
  logic                  oversize;

  assign rx_ready  = (state == IDLE) || (state == HDR) ||
                     (state == DATA) || (state == CSUM);
  assign accept    = rx_valid && rx_ready;
  assign word_full = (byte_cnt == 2'd3);
  // The byte on the wire completes the big-endian word when word_full.
  assign cur_word  = {shreg, rx_data};
  // word_count >= 1 whenever DATA is active, so N-1 cannot underflow there.
  assign last_word = (32'(word_addr) == (word_count - 32'd1));
  assign oversize  = ({1'b0, cur_word} > MAX_WORDS);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_next = HDR;
      end
      HDR: begin
        if (accept && word_full) begin
          if (oversize)                state_next = ERROR;
          else if (cur_word == 32'd0)  state_next = CSUM;
          else                         state_next = DATA;
        end
      end
      DATA: begin
        if (accept && word_full && last_word) state_next = CSUM;
      end
      CSUM: begin
        if (accept && word_full) begin
          state_next = (cur_word == sum) ? DONE : ERROR;
        end
      end
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: byte assembly, word count, address, running sum, write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      word_count <= 32'd0;
      sum        <= 32'd0;
      word_addr  <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= 32'd0;
    end else begin
      im_we <= 1'b0;
      if (accept && ((state == HDR) || (state == DATA) || (state == CSUM))) begin
        byte_cnt <= byte_cnt + 2'd1;
        shreg    <= {shreg[15:0], rx_data};
        if (word_full) begin
          case (state)
            HDR: begin
              word_count <= cur_word;
              word_addr  <= '0;
              sum        <= 32'd0;
            end
            DATA: begin
              im_we     <= 1'b1;
              im_addr   <= word_addr;
              im_wdata  <= cur_word;
              sum       <= sum + cur_word;
              // After the last word this may roll over, but it is never used
              // again because the FSM has left DATA.
              word_addr <= word_addr + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Registered status outputs, decoded from the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cpu_reset <= (state_next != DONE);
      done      <= (state_next == DONE);
      error     <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader.
module tb_boot_loader;

  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected memory writes: {addr, data}
  logic [AW+31:0] exp_q[$];

  boot_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every im_we pulse must match the head of the queue.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {20'd0, im_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("im_addr", {20'd0, im_addr}, {20'd0, e[AW+31:32]});
        check("im_wdata", im_wdata, e[31:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle_cycles(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], $urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},       {31'd0, im_we},     32'd0);
    check({tag, "_addr"},     {20'd0, im_addr},   32'd0);
    check({tag, "_wdata"},    im_wdata,           32'd0);
    check({tag, "_cpu_rst"},  {31'd0, cpu_reset}, 32'd1);
    check({tag, "_done"},     {31'd0, done},      32'd0);
    check({tag, "_error"},    {31'd0, error},     32'd0);
    check({tag, "_ready"},    {31'd0, rx_ready},  32'd1);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"},    {31'd0, done},      32'd1);
    check({tag, "_cpu_rst"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_error"},   {31'd0, error},     32'd0);
    check({tag, "_ready"},   {31'd0, rx_ready},  32'd0);
  endtask

  task automatic check_error(input string tag);
    check({tag, "_done"},    {31'd0, done},      32'd0);
    check({tag, "_cpu_rst"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_error"},   {31'd0, error},     32'd1);
    check({tag, "_ready"},   {31'd0, rx_ready},  32'd0);
  endtask

  task automatic expect_two_writes();
    exp_q.push_back({12'd0, 32'h0000_0004});
    exp_q.push_back({12'd1, 32'h2008_0005});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check_reset_values("async_rst");
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);
    check_reset_values("post_rst");

    // Scenario 1: good two-word frame, explicit write-latency checks.
    expect_two_writes();
    send_byte(8'hA5, 0);
    send_word(32'h0000_0002, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    check("s1_we0_lat",   {31'd0, im_we},   32'd1);
    check("s1_addr0_lat", {20'd0, im_addr}, 32'd0);
    send_byte(8'h20, 0);
    check("s1_we_drop",   {31'd0, im_we},   32'd0);
    send_byte(8'h08, 0); send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    check("s1_we1_lat",   {31'd0, im_we},    32'd1);
    check("s1_wdata1",    im_wdata,          32'h2008_0005);
    check("s1_cpu_held",  {31'd0, cpu_reset}, 32'd1);
    send_word(32'h2008_0009, 0);
    check_done("s1");
    // DONE ignores further traffic.
    send_word(32'hA5A5_A5A5, 0);
    check_done("s1_ignore");
    check("s1_writes_left", exp_q.size(), 32'd0);

    // Scenario 2: bad checksum.
    do_reset();
    expect_two_writes();
    send_byte(8'hA5, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0004, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h2008_000A, 0);
    check_error("s2");
    send_byte(8'hA5, 0);
    check_error("s2_no_resync");
    check("s2_writes_left", exp_q.size(), 32'd0);

    // Scenario 3: leading garbage and random idle gaps.
    do_reset();
    expect_two_writes();
    send_byte(8'h00, $urandom_range(0, 5));
    send_byte(8'hFF, $urandom_range(0, 5));
    send_byte(8'h3C, $urandom_range(0, 5));
    check("s3_idle_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(8'hA5, $urandom_range(0, 5));
    send_word(32'h0000_0002, 5);
    send_word(32'h0000_0004, 5);
    send_word(32'h2008_0005, 5);
    send_word(32'h2008_0009, 5);
    check_done("s3");
    check("s3_writes_left", exp_q.size(), 32'd0);

    // Scenario 4: oversized N = 4097.
    do_reset();
    send_byte(8'hA5, 0);
    send_word(32'h0000_1001, 0);
    check_error("s4");
    send_word(32'h0000_0004, 0);
    check_error("s4_hold");

    // Scenario 4b: N = 4096 exactly is legal; loader stays in DATA.
    do_reset();
    send_byte(8'hA5, 0);
    send_word(32'h0000_1000, 0);
    check("s4b_error", {31'd0, error},    32'd0);
    check("s4b_ready", {31'd0, rx_ready}, 32'd1);
    check("s4b_done",  {31'd0, done},     32'd0);

    // Scenario 5: empty image.
    do_reset();
    send_byte(8'hA5, 0);
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_0000, 0);
    check_done("s5");

    // Scenario 6: reset mid word 1, then full retransmit.
    do_reset();
    exp_q.push_back({12'd0, 32'h0000_0004});
    send_byte(8'hA5, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0004, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    reset = 1'b1;
    #1;
    check_reset_values("s6_async");
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);
    check_reset_values("s6_post");
    // A non-sync byte right after reset must be discarded.
    send_byte(8'h05, 0);
    expect_two_writes();
    send_byte(8'hA5, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0004, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h2008_0009, 0);
    check_done("s6");
    check("s6_writes_left", exp_q.size(), 32'd0);

    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
